// File: rtl/req_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : req_onehot_arbiter
//  Description : Round-robin one-hot request arbiter that feeds the 4-to-2
//                encoder stage. Grants at most one requester at a time, with
//                a hold timer, an early-release handshake (ack) and a
//                one-cycle idle gap between grants. All outputs registered.
//  Options     : `define REQ_SYNC_EN  -> two-flop synchronizer on each req bit
//                                        (adds 2 cycles of request latency)
//  Revision    : 1.0  initial release
// ============================================================================
module req_onehot_arbiter #(
    parameter int HOLD_CYCLES = 4               // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter load value: a grant lasts counter+1 cycles, so HOLD_CYCLES total.
    localparam logic [7:0] c_hold_load = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_last;      // index of the most recently granted requester

    logic [3:0] w_r;         // request vector as seen by the arbiter
    logic [1:0] w_pick;
    logic       w_found;
    logic [1:0] w_cand;
    logic       w_release;

`ifdef REQ_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Two-flop synchronizer for asynchronous request lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= req;
            r_sync2 <= r_sync1;
        end
    end

    assign w_r = r_sync2;
`else
    // Requests are already synchronous to clk and are used as-is.
    assign w_r = req;
`endif

    // Round-robin search: first set bit starting just after the last grant.
    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        w_cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && w_r[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // A grant ends on consumer ack, on loss of the granted request, or on
    // hold-timer expiry; any combination of these is a single release.
    assign w_release = ack | ~w_r[grant_idx] | (r_cnt == 8'd0);

    // Arbiter state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 2'd3;
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
            grant_idx   <= 2'd0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state     <= ST_GRANT;
                        r_cnt       <= c_hold_load;
                        r_last      <= w_pick;
                        grant       <= 4'b0001 << w_pick;
                        grant_valid <= 1'b1;
                        grant_idx   <= w_pick;
                        busy        <= 1'b1;
                    end
                end

                ST_GRANT: begin
                    if (w_release) begin
                        r_state     <= ST_GAP;
                        r_cnt       <= 8'd0;
                        grant       <= 4'b0000;
                        grant_valid <= 1'b0;
                        grant_idx   <= 2'd0;
                    end else begin
                        // Non-zero here, since zero would have released.
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                ST_GAP: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 8'd0;
                    grant       <= 4'b0000;
                    grant_valid <= 1'b0;
                    grant_idx   <= 2'd0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_req_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_onehot_arbiter
//  Description : Self-checking bench for req_onehot_arbiter (HOLD_CYCLES=4,
//                default build without request synchronizer).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_req_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] exp_grant;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    req_onehot_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    // One-hot invariant on grant, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
        end
    end

    // Drive one cycle of stimulus, push the expectation, then pop and compare
    // the registered outputs just after the edge that produces them.
    task automatic step(input logic [3:0] r, input logic a, input logic [3:0] eg, input logic eb,
                        input string tag);
        exp_t e;
        req = r;
        ack = a;
        e.grant = eg;
        e.busy  = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_grant"}, {4'd0, grant}, {4'd0, e.grant});
            check({tag, "_valid"}, {7'd0, grant_valid}, {7'd0, (e.grant != 4'b0000)});
            check({tag, "_idx"},   {6'd0, grant_idx}, {6'd0, enc(e.grant)});
            check({tag, "_busy"},  {7'd0, busy}, {7'd0, e.busy});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Round-robin table under continuous requests: each grant lasts 4
        // cycles, then one GAP cycle (busy) and one IDLE cycle (not busy).
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) tbl.push_back('{4'b1111, 1'b0, 4'b0001 << g, 1'b1});
            tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1});
            tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b0});
        end
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1});

        // Reset state with all requests active.
        rst = 1'b1;
        req = 4'b1111;
        ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", {4'd0, grant}, 8'h00);
        check("rst_valid", {7'd0, grant_valid}, 8'h00);
        check("rst_idx",   {6'd0, grant_idx}, 8'h00);
        check("rst_busy",  {7'd0, busy}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].ack, tbl[i].exp_grant, tbl[i].exp_busy, $sformatf("rr%0d", i));
        end

        // Single request held: 4 grant cycles, 2 empty cycles, grant again.
        do_reset();
        for (int c = 0; c < 4; c++) step(4'b0100, 1'b0, 4'b0100, 1'b1, "single");
        step(4'b0100, 1'b0, 4'b0000, 1'b1, "single_gap");
        step(4'b0100, 1'b0, 4'b0000, 1'b0, "single_idle");
        step(4'b0100, 1'b0, 4'b0100, 1'b1, "single_again");

        // Early release on the 2nd grant cycle; ack in GAP/IDLE is ignored.
        do_reset();
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "early_g1");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "early_g2");
        step(4'b0010, 1'b1, 4'b0000, 1'b1, "early_rel");
        step(4'b0010, 1'b1, 4'b0000, 1'b0, "ack_in_gap");
        step(4'b0010, 1'b1, 4'b0010, 1'b1, "ack_in_idle");
        step(4'b0010, 1'b1, 4'b0000, 1'b1, "ack_rel2");

        // Granted bit drops; other bits toggling do not disturb a grant;
        // ack coinciding with hold expiry is a single release.
        do_reset();
        step(4'b0011, 1'b0, 4'b0001, 1'b1, "drop_g");
        step(4'b0010, 1'b0, 4'b0000, 1'b1, "drop_rel");
        step(4'b0010, 1'b0, 4'b0000, 1'b0, "drop_idle");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "next_g1");
        step(4'b0011, 1'b0, 4'b0010, 1'b1, "other_up");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "other_dn");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "next_g4");
        step(4'b0010, 1'b1, 4'b0000, 1'b1, "ack_expiry");
        step(4'b0010, 1'b0, 4'b0000, 1'b0, "ack_exp_idle");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "ack_exp_regrant");

        // Asynchronous reset in the middle of a grant, then fresh priority.
        do_reset();
        step(4'b1000, 1'b0, 4'b1000, 1'b1, "mid_g");
        #3;
        rst = 1'b1;
        #1;
        check("async_grant", {4'd0, grant}, 8'h00);
        check("async_busy",  {7'd0, busy}, 8'h00);
        check("async_valid", {7'd0, grant_valid}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1001, 1'b0, 4'b0001, 1'b1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
